// File: rtl/fp_multiplier_pipe.sv
// Three-stage IEEE-style floating-point multiplier with valid/ready flow control.
// Subnormal inputs and underflowing results are flushed to zero; rounding is
// round-to-nearest-even; NaN results are always the canonical quiet NaN.
module fp_multiplier_pipe #(
    parameter  int unsigned EXP_W  = 8,
    parameter  int unsigned MAN_W  = 23,
    localparam int unsigned DATA_W = 1 + EXP_W + MAN_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DATA_W-1:0] dataA_i,
    input  logic [DATA_W-1:0] dataB_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [DATA_W-1:0] data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [3:0]        flags_o
);

    localparam int unsigned BIAS    = (1 << (EXP_W - 1)) - 1;
    localparam int unsigned EXP_MAX = (1 << EXP_W) - 1;
    localparam int unsigned EXPS_W  = EXP_W + 2;
    localparam int unsigned SIG_W   = MAN_W + 1;
    localparam int unsigned PROD_W  = 2 * SIG_W;

    localparam logic [DATA_W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};

    // Flag bit positions: {nv, of, uf, nx}
    localparam logic [3:0] FLAG_NV = 4'b1000;
    localparam logic [3:0] FLAG_OF_NX = 4'b0101;
    localparam logic [3:0] FLAG_UF_NX = 4'b0011;

    logic advance;

    // Operand fields
    logic              signA, signB;
    logic [EXP_W-1:0]  expA, expB;
    logic [MAN_W-1:0]  fracA, fracB;

    // Stage 1 next values
    logic                     aZero, bZero, aInf, bInf, aNan, bNan, aSnan, bSnan;
    logic                     signP;
    logic signed [EXPS_W-1:0] expSumD;
    logic                     specialD;
    logic [DATA_W-1:0]        specDataD;
    logic [3:0]               specFlagsD;

    // Stage 1 registers
    logic                     s1Valid;
    logic                     s1Sign;
    logic signed [EXPS_W-1:0] s1ExpSum;
    logic [SIG_W-1:0]         s1ManA, s1ManB;
    logic                     s1Special;
    logic [DATA_W-1:0]        s1SpecData;
    logic [3:0]               s1SpecFlags;

    // Stage 2 registers
    logic                     s2Valid;
    logic                     s2Sign;
    logic signed [EXPS_W-1:0] s2ExpSum;
    logic [PROD_W-1:0]        s2Prod;
    logic                     s2Special;
    logic [DATA_W-1:0]        s2SpecData;
    logic [3:0]               s2SpecFlags;

    // Stage 3 combinational result
    logic signed [EXPS_W-1:0] expAdj, expFinal;
    logic [MAN_W-1:0]         frac, fracRnd;
    logic                     guardBit, stickyBit, roundUp, carry;
    logic [DATA_W-1:0]        s3Data;
    logic [3:0]               s3Flags;

    // Output registers
    logic              outValidQ;
    logic [DATA_W-1:0] dataQ;
    logic [3:0]        flagsQ;

    assign advance     = !outValidQ || out_ready_i;
    assign in_ready_o  = advance;
    assign out_valid_o = outValidQ;
    assign data_o      = dataQ;
    assign flags_o     = flagsQ;

    assign signA = dataA_i[DATA_W-1];
    assign signB = dataB_i[DATA_W-1];
    assign expA  = dataA_i[DATA_W-2:MAN_W];
    assign expB  = dataB_i[DATA_W-2:MAN_W];
    assign fracA = dataA_i[MAN_W-1:0];
    assign fracB = dataB_i[MAN_W-1:0];

    // S1: classify operands, resolve special-case result, biased exponent sum
    always_comb begin
        aZero      = (expA == '0);
        bZero      = (expB == '0);
        aInf       = (&expA) && (fracA == '0);
        bInf       = (&expB) && (fracB == '0);
        aNan       = (&expA) && (fracA != '0);
        bNan       = (&expB) && (fracB != '0);
        aSnan      = aNan && !fracA[MAN_W-1];
        bSnan      = bNan && !fracB[MAN_W-1];
        signP      = signA ^ signB;
        expSumD    = EXPS_W'(expA) + EXPS_W'(expB) - EXPS_W'(BIAS);
        specialD   = 1'b0;
        specDataD  = '0;
        specFlagsD = '0;
        if (aNan || bNan) begin
            specialD   = 1'b1;
            specDataD  = QNAN;
            specFlagsD = (aSnan || bSnan) ? FLAG_NV : 4'b0000;
        end else if ((aInf && bZero) || (aZero && bInf)) begin
            specialD   = 1'b1;
            specDataD  = QNAN;
            specFlagsD = FLAG_NV;
        end else if (aInf || bInf) begin
            specialD   = 1'b1;
            specDataD  = {signP, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (aZero || bZero) begin
            specialD   = 1'b1;
            specDataD  = {signP, {(DATA_W - 1){1'b0}}};
        end
    end

    // S3: normalise, round to nearest even, range-check and apply special override
    always_comb begin
        expAdj    = s2ExpSum;
        frac      = '0;
        guardBit  = 1'b0;
        stickyBit = 1'b0;
        if (s2Prod[PROD_W-1]) begin
            expAdj    = s2ExpSum + EXPS_W'(1);
            frac      = s2Prod[PROD_W-2 -: MAN_W];
            guardBit  = s2Prod[MAN_W];
            stickyBit = |s2Prod[MAN_W-1:0];
        end else begin
            frac      = s2Prod[PROD_W-3 -: MAN_W];
            guardBit  = s2Prod[MAN_W-1];
            stickyBit = |s2Prod[MAN_W-2:0];
        end
        roundUp          = guardBit && (stickyBit || frac[0]);
        {carry, fracRnd} = {1'b0, frac} + SIG_W'(roundUp);
        expFinal         = expAdj + EXPS_W'(carry);
        s3Data           = {s2Sign, expFinal[EXP_W-1:0], fracRnd};
        s3Flags          = {3'b000, guardBit || stickyBit};
        if (s2Special) begin
            s3Data  = s2SpecData;
            s3Flags = s2SpecFlags;
        end else if (expFinal >= $signed(EXPS_W'(EXP_MAX))) begin
            s3Data  = {s2Sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            s3Flags = FLAG_OF_NX;
        end else if (expFinal <= $signed(EXPS_W'(0))) begin
            s3Data  = {s2Sign, {(DATA_W - 1){1'b0}}};
            s3Flags = FLAG_UF_NX;
        end
    end

    // Valid bits and output registers; everything holds while stalled
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1Valid   <= 1'b0;
            s2Valid   <= 1'b0;
            outValidQ <= 1'b0;
            dataQ     <= '0;
            flagsQ    <= '0;
        end else if (advance) begin
            s1Valid   <= in_valid_i;
            s2Valid   <= s1Valid;
            outValidQ <= s2Valid;
            if (s2Valid) begin
                dataQ  <= s3Data;
                flagsQ <= s3Flags;
            end
        end
    end

    // S1/S2 datapath registers, no reset needed
    always_ff @(posedge clk_i) begin
        if (advance) begin
            s1Sign      <= signP;
            s1ExpSum    <= expSumD;
            s1ManA      <= {1'b1, fracA};
            s1ManB      <= {1'b1, fracB};
            s1Special   <= specialD;
            s1SpecData  <= specDataD;
            s1SpecFlags <= specFlagsD;
            s2Sign      <= s1Sign;
            s2ExpSum    <= s1ExpSum;
            s2Prod      <= PROD_W'(s1ManA) * PROD_W'(s1ManB);
            s2Special   <= s1Special;
            s2SpecData  <= s1SpecData;
            s2SpecFlags <= s1SpecFlags;
        end
    end

endmodule
